gpu_frame_reader: RTL

- Read-side master for the 8-bit GPU read port of the processor memory block.
- After a start pulse, it walks a linear pixel address range and drives gpu_address.
- It captures the returned encrypted or decrypted byte and emits a pixel stream under valid/ready handshake to the video/display pipeline.
- A 2-entry skid FIFO absorbs the 1-cycle memory read latency, so downstream stalls never drop or duplicate pixels.

---
 rtl/gpu_reader_pkg.sv | 22 ++
 rtl/gpu_frame_reader_skid_fifo.sv | 65 ++++++
 rtl/gpu_frame_reader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/gpu_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_reader_pkg
//  Description : Shared types and constants for the GPU frame reader slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_reader_pkg;

    // Frame-read control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    // Skid FIFO geometry: two slots cover one entry in flight plus one held
    localparam int FIFO_DEPTH = 2;
    localparam int PIX_W      = 8;
    localparam int CNT_W      = 2;

endpackage : gpu_reader_pkg
`default_nettype wire

// File: rtl/gpu_frame_reader_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_skid_fifo
//  Description : 2-entry, 8-bit synchronous FIFO absorbing the memory read
//                latency. Head byte is presented combinationally from storage
//                so it stays stable until popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_skid_fifo
    import gpu_reader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [PIX_W-1:0] push_data,
    input  logic             pop,
    output logic [PIX_W-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PIX_W-1:0] r_mem [FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves the same cycle
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : pixel_skid_fifo
`default_nettype wire

// File: rtl/gpu_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_frame_reader
//  Description : Read-side master for the 8-bit GPU memory port. Walks a
//                linear pixel range, captures the returned encrypted or
//                decrypted byte and streams it out under valid/ready with
//                x/y position and an end-of-frame pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_frame_reader
    import gpu_reader_pkg::*;
#(
    parameter int          IMG_W     = 256,
    parameter int          IMG_H     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          XY_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             image_select,
    output logic [31:0]      gpu_address,
    input  logic [7:0]       encrypted_gpu,
    input  logic [7:0]       decrypted_gpu,
    output logic [7:0]       pixel_data,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic [XY_W-1:0]  pixel_x,
    output logic [XY_W-1:0]  pixel_y,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [31:0]     TOTAL  = 32'(IMG_W * IMG_H);
    localparam logic [XY_W-1:0] X_LAST = XY_W'(IMG_W - 1);
    localparam logic [XY_W-1:0] Y_LAST = XY_W'(IMG_H - 1);

    reader_state_t    r_state;
    logic [31:0]      r_issue_cnt;
    logic             r_inflight;
    logic             r_sel;

    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_pop;
    logic [2:0]       w_credit;
    logic             w_issue;
    logic             w_last_issue;
    logic             w_drained;
    logic             w_start_accept;
    logic [7:0]       w_capture;

    assign pixel_valid = !w_empty;
    assign w_pop       = pixel_valid && pixel_ready;

    // Slots committed after this edge: a pop in the same cycle frees one,
    // which is what lets the stream run at one pixel per cycle.
    assign w_credit = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue  = (r_state == READ) && (w_credit < 3'd2);

    assign w_last_issue = (r_issue_cnt == TOTAL - 32'd1);

    // Done when nothing is in flight and the FIFO is empty after this edge
    assign w_drained = !r_inflight && !w_full && (w_empty || w_pop);

    // A start coinciding with the end-of-frame pulse is deliberately dropped
    assign w_start_accept = (r_state == IDLE) && start && !frame_done;

    // Capture always follows the image chosen when the frame was started
    assign w_capture = r_sel ? decrypted_gpu : encrypted_gpu;

    pixel_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (r_inflight),
        .push_data (w_capture),
        .pop       (w_pop),
        .pop_data  (pixel_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Frame control: state, read issue, address generation and busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_inflight  <= 1'b0;
            r_sel       <= 1'b0;
            busy        <= 1'b0;
            gpu_address <= BASE_ADDR;
        end else begin
            // The address present during an issuing cycle returns next cycle
            r_inflight <= w_issue;
            case (r_state)
                IDLE: begin
                    if (w_start_accept) begin
                        r_sel       <= image_select;
                        r_issue_cnt <= '0;
                        gpu_address <= BASE_ADDR;
                        busy        <= 1'b1;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + 32'd1;
                        if (w_last_issue) begin
                            // Address stays on the final pixel of the frame
                            r_state <= DRAIN;
                        end else begin
                            gpu_address <= BASE_ADDR + r_issue_cnt + 32'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output-side pixel position and end-of-frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_x    <= '0;
            pixel_y    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_start_accept) begin
                pixel_x <= '0;
                pixel_y <= '0;
            end else if (w_pop) begin
                if (pixel_x == X_LAST) begin
                    pixel_x <= '0;
                    if (pixel_y == Y_LAST) begin
                        pixel_y    <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        pixel_y <= pixel_y + XY_W'(1);
                    end
                end else begin
                    pixel_x <= pixel_x + XY_W'(1);
                end
            end
        end
    end

endmodule : gpu_frame_reader
`default_nettype wire
